// File: rtl/reg_status_file_pkg.sv
// Shared widths and helpers for the register/rename-status file.
// Imported by reg_status_file and rsf_read_port.
package reg_status_file_pkg;

  localparam int XLEN      = 32;
  localparam int NREG      = 32;
  localparam int REG_IDX_W = 5;
  localparam int TAG_W     = 4;
  localparam int CNT_W     = 6;

  // A busy operand carries the producer tag, zero-extended to XLEN.
  function automatic logic [XLEN-1:0] tag2op(
    input logic [TAG_W-1:0] t
  );
    return {{(XLEN-TAG_W){1'b0}}, t};
  endfunction

  function automatic logic [CNT_W-1:0] popcnt(
    input logic [NREG-1:0] v
  );
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < NREG; i++) begin
      c = c + CNT_W'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/reg_status_file_read_port.sv
// rsf_read_port: one combinational operand lookup port.
// Ports: addr_i, register state (busy_i/tag_i/val_i), commit
// bus (cm_*_i) for the optional bypass; ready_o/val_o operand.
// Macro REGFILE_COMMIT_BYPASS_EN enables same-cycle commit bypass.
module rsf_read_port
  import reg_status_file_pkg::*;
(
  input  logic [REG_IDX_W-1:0]       addr_i,
  input  logic [NREG-1:0]            busy_i,
  input  logic [NREG-1:0][TAG_W-1:0] tag_i,
  input  logic [NREG-1:0][XLEN-1:0]  val_i,
  input  logic                       cm_en_i,
  input  logic [REG_IDX_W-1:0]       cm_idx_i,
  input  logic [TAG_W-1:0]           cm_tag_i,
  input  logic [XLEN-1:0]            cm_val_i,
  output logic                       ready_o,
  output logic [XLEN-1:0]            val_o
);

`ifdef REGFILE_COMMIT_BYPASS_EN
  localparam bit BYPASS_EN = 1'b1;
`else
  localparam bit BYPASS_EN = 1'b0;
`endif

  logic             is_x0;
  logic             busy;
  logic [TAG_W-1:0] tag;
  logic             hit;
  logic             sel_x0;
  logic             sel_val;
  logic             sel_byp;
  logic             sel_tag;

  assign is_x0 = (addr_i == '0);
  assign busy  = busy_i[addr_i];
  assign tag   = tag_i[addr_i];

  // The retiring op is exactly the producer this port waits on.
  assign hit = BYPASS_EN
             & cm_en_i
             & (cm_idx_i == addr_i)
             & (cm_tag_i == tag);

  assign sel_x0  = is_x0;
  assign sel_val = !is_x0 & !busy;
  assign sel_byp = !is_x0 &  busy &  hit;
  assign sel_tag = !is_x0 &  busy & !hit;

  always_comb begin
    ready_o = 1'b1;
    val_o   = '0;
    unique case (1'b1)
      sel_x0: begin
        ready_o = 1'b1;
        val_o   = '0;
      end
      sel_val: begin
        ready_o = 1'b1;
        val_o   = val_i[addr_i];
      end
      sel_byp: begin
        ready_o = 1'b1;
        val_o   = cm_val_i;
      end
      sel_tag: begin
        ready_o = 1'b0;
        val_o   = tag2op(tag);
      end
      default: begin
        ready_o = 1'b1;
        val_o   = '0;
      end
    endcase
  end

endmodule

// File: rtl/reg_status_file.sv
// Architectural register file with per-register rename status.
// Ports: clk/rst (sync, active-high), rdy freeze, flush, rename
// (rn_*), commit (cm_*), two lookups (rs1_*/rs2_*), busy_cnt.
// Macro REGFILE_COMMIT_BYPASS_EN: lookup sees same-cycle commit.
module reg_status_file
  import reg_status_file_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 flush,
  input  logic                 rn_en,
  input  logic [REG_IDX_W-1:0] rn_idx,
  input  logic [TAG_W-1:0]     rn_tag,
  input  logic                 cm_en,
  input  logic [REG_IDX_W-1:0] cm_idx,
  input  logic [XLEN-1:0]      cm_val,
  input  logic [TAG_W-1:0]     cm_tag,
  input  logic [REG_IDX_W-1:0] rs1_addr,
  input  logic [REG_IDX_W-1:0] rs2_addr,
  output logic                 rs1_ready,
  output logic [XLEN-1:0]      rs1_val,
  output logic                 rs2_ready,
  output logic [XLEN-1:0]      rs2_val,
  output logic [CNT_W-1:0]     busy_cnt
);

  logic [NREG-1:0][XLEN-1:0]  val_q, val_d;
  logic [NREG-1:0][TAG_W-1:0] tag_q, tag_d;
  logic [NREG-1:0]            busy_q, busy_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;

  logic rn_go;
  logic cm_go;
  logic cm_clr;

  assign rn_go = rn_en & !flush & (rn_idx != '0);
  assign cm_go = cm_en & (cm_idx != '0);

  // Only the current producer's retire frees the register;
  // a stale (WAW-overwritten) tag leaves busy/tag alone.
  assign cm_clr = cm_go
                & busy_q[cm_idx]
                & (tag_q[cm_idx] == cm_tag);

  always_comb begin
    val_d  = val_q;
    tag_d  = tag_q;
    busy_d = busy_q;
    cnt_d  = cnt_q;

    if (cm_go) begin
      val_d[cm_idx] = cm_val;
    end
    if (cm_clr) begin
      busy_d[cm_idx] = 1'b0;
    end
    // Rename after commit so a same-index pair keeps busy.
    if (rn_go) begin
      busy_d[rn_idx] = 1'b1;
      tag_d[rn_idx]  = rn_tag;
    end
    if (flush) begin
      busy_d = '0;
    end

    cnt_d = popcnt(busy_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      val_q  <= '0;
      tag_q  <= '0;
      busy_q <= '0;
      cnt_q  <= '0;
    end else if (rdy) begin
      val_q  <= val_d;
      tag_q  <= tag_d;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_cnt = cnt_q;

  rsf_read_port u_rs1 (
    .addr_i   (rs1_addr),
    .busy_i   (busy_q),
    .tag_i    (tag_q),
    .val_i    (val_q),
    .cm_en_i  (cm_en),
    .cm_idx_i (cm_idx),
    .cm_tag_i (cm_tag),
    .cm_val_i (cm_val),
    .ready_o  (rs1_ready),
    .val_o    (rs1_val)
  );

  rsf_read_port u_rs2 (
    .addr_i   (rs2_addr),
    .busy_i   (busy_q),
    .tag_i    (tag_q),
    .val_i    (val_q),
    .cm_en_i  (cm_en),
    .cm_idx_i (cm_idx),
    .cm_tag_i (cm_tag),
    .cm_val_i (cm_val),
    .ready_o  (rs2_ready),
    .val_o    (rs2_val)
  );

endmodule

// File: doc/reg_status_file.md
Name: reg_status_file

Overview:
Architectural register file with per-register rename status. It is the responder side of the reorder-buffer interface: it accepts rename requests at dispatch, commit write-backs at retire, and operand lookups at dispatch.
- A lookup returns either the committed value, or the reorder tag of the producing in-flight instruction.
- Sits between decode/ROB dispatch and the RS/LSB operand path; flushed on branch/JALR redirect.

Parameters:
XLEN, 32, data width
NREG, 32, architectural register count (index width log2(NREG)=5)
TAG_W, 4, reorder tag width (16-entry ROB)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
rdy  in  1  global enable; low = freeze all state
flush  in  1  redirect; clear all rename status
rn_en  in  1  rename request (dispatch of rd-writing op)
rn_idx  in  5  destination register being renamed
rn_tag  in  TAG_W  ROB slot allocated to the producer
cm_en  in  1  commit write-back
cm_idx  in  5  committed destination register
cm_val  in  XLEN  committed value
cm_tag  in  TAG_W  ROB slot being retired
rs1_addr  in  5  lookup port 1 index
rs2_addr  in  5  lookup port 2 index
rs1_ready  out  1  1 = rs1_val is a value; 0 = rs1_val is a tag
rs1_val  out  XLEN  value, or tag zero-extended to XLEN
rs2_ready  out  1  as rs1_ready
rs2_val  out  XLEN  as rs1_val
busy_cnt  out  6  number of currently renamed registers (registered)

Behaviour:
- State per register: val[XLEN], busy[1], tag[TAG_W].
- Reset: all val=0, busy=0, tag=0, busy_cnt=0. A reset mid-operation discards all renames. No output is registered except busy_cnt, so all lookup outputs follow the cleared state on the next cycle.
- rdy=0: no state changes. Lookups remain combinational on the frozen state.
- x0: never written, never busy. Rename or commit to index 0 is ignored. A lookup of x0 returns ready=1, val=0.
- Rename (rn_en & rdy & !flush & rn_idx!=0): at the clock edge, busy[rn_idx]<=1 and tag[rn_idx]<=rn_tag. This overwrites any older tag (WAW).
- Commit (cm_en & rdy & cm_idx!=0):
  - val[cm_idx]<=cm_val unconditionally.
  - busy[cm_idx]<=0 only if busy & tag==cm_tag and there is no same-cycle rename of the same index.
  - A commit to a register renamed by a younger op leaves busy/tag untouched.
- Rename and commit of the same index in the same cycle: the value is written; busy=1 and tag=rn_tag (the rename wins).
- Flush (flush & rdy): all busy<=0 at the edge and rename is ignored. A same-cycle commit still writes val.
- Lookup is combinational, 0-cycle, and reflects pre-edge state. A same-cycle rename never affects a lookup: "addi x1,x1,1" sees the old x1 mapping.
- Lookup per port:
  - not busy -> ready=1, val=val[idx];
  - busy -> ready=0, val={0,tag[idx]};
  - with the bypass (see Optional Feature) a matching commit overrides this.
- busy_cnt: registered count of busy bits, updated at the same edge as busy. It is 0 after flush or reset, and never exceeds 31.

Optional Feature:
REGFILE_COMMIT_BYPASS_EN.
- Defined: if a port reads a busy register whose tag==cm_tag while cm_en & cm_idx==idx, the port returns ready=1, val=cm_val in the same cycle.
- Undefined: the port returns ready=0 with the tag. The ROB/CDB forwarding path resolves the operand.
- Sequential state is identical either way.

Decomposition:
- Shared package holds: XLEN, TAG_W, REG_IDX_W=5, NREG, and the tag-to-operand zero-extend function.
- One natural sub-module, rsf_read_port, instantiated twice. It contains the index-0 check, busy/tag select and the optional bypass mux.
- The top level owns the arrays, the update priority (flush > rename > commit for busy/tag) and busy_cnt.

Test Plan:
- Reset, then read rs1=5, rs2=0 -> ready=1/1, val=0/0, busy_cnt=0.
- Rename x5 tag 3. Next cycle read x5 -> ready=0, val=3, busy_cnt=1. Commit x5 tag 3 val 0xDEAD. Next cycle read -> ready=1, val=0xDEAD, busy_cnt=0.
- WAW case:
  - rename x7 tag 2, then rename x7 tag 9;
  - commit x7 tag 2 val 0x11 -> x7 still ready=0, val=9;
  - commit tag 9 val 0x22 -> ready=1, val=0x22.
- Same-cycle events:
  - rename x4 tag 6 while reading rs1=4 (x4 idle, val 0x40) -> same cycle ready=1, val=0x40; next cycle ready=0, val=6;
  - rename+commit x4 same cycle -> busy kept, tag=new.
- Flush: rename x1, x2, x3 (busy_cnt=3), then flush with commit x2 val 0x77 -> next cycle all ready, x2=0x77, busy_cnt=0; rename in the flush cycle is dropped.
- Bypass: with the macro, busy x8 tag 4, commit x8 tag 4 val 0x99 while reading rs2=8 -> same cycle ready=1, val=0x99. Without the macro -> ready=0, val=4.
